// File: rtl/k_add_scheduler.sv
// Round-robin scheduler sharing one 2-bit digit-serial adder among NUM_REQ requesters.
// Operands are captured at grant and summed LSB digit first; the result returns over valid/ready.

module k_add_cell (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};
endmodule

module k_add_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);
  localparam int D     = WIDTH / 2;
  localparam int CNT_W = (D > 1) ? $clog2(D) : 1;
  localparam int PW    = ID_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, id_reg, grant_idx, rr_next;
  logic              grant_found, handshake;
  logic [PW-1:0]     idx_sum, grant_plus;
  logic [CNT_W-1:0]  cnt_reg;
  logic              carry_reg;
  logic [WIDTH-1:0]  a_reg, b_reg, result;
  logic [WIDTH-1:0]  a_arr [NUM_REQ];
  logic [WIDTH-1:0]  b_arr [NUM_REQ];
  logic [1:0]        a_dig [D];
  logic [1:0]        b_dig [D];
  logic [1:0]        result_dig [D];
  logic [1:0]        cell_s;
  logic              cell_cout;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
    for (gi = 0; gi < D; gi++) begin : g_digits
      assign a_dig[gi] = a_reg[2*gi +: 2];
      assign b_dig[gi] = b_reg[2*gi +: 2];
      assign result[2*gi +: 2] = result_dig[gi];
      always_ff @(posedge clk) begin
        if (rst)
          result_dig[gi] <= 2'b00;
        else if (state_reg == RUN && cnt_reg == CNT_W'(gi))
          result_dig[gi] <= cell_s;
      end
    end
  endgenerate

  k_add_cell u_cell (
    .a    (a_dig[cnt_reg]),
    .b    (b_dig[cnt_reg]),
    .cin  (carry_reg),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_sum     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_sum = {1'b0, rr_ptr_reg} + PW'(off);
      if (idx_sum >= PW'(NUM_REQ))
        idx_sum = idx_sum - PW'(NUM_REQ);
      if (!grant_found && req_valid[idx_sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_sum[ID_W-1:0];
      end
    end
  end

  assign handshake  = (state_reg == IDLE) && grant_found && !rst;
  assign grant_plus = {1'b0, grant_idx} + PW'(1);
  assign rr_next    = (grant_plus == PW'(NUM_REQ)) ? '0 : grant_plus[ID_W-1:0];

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = RUN;
      RUN:     if (cnt_reg == CNT_W'(D-1)) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else if (handshake) begin
      a_reg      <= a_arr[grant_idx];
      b_reg      <= b_arr[grant_idx];
      id_reg     <= grant_idx;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      rr_ptr_reg <= rr_next;
    end else if (state_reg == RUN) begin
      carry_reg  <= cell_cout;
      cnt_reg    <= cnt_reg + CNT_W'(1);
    end
  end

  // Response fields read as zero outside RESP so nothing stale leaks out.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    rsp_sum   = '0;
    rsp_cout  = 1'b0;
    rsp_id    = '0;
    busy      = (state_reg != IDLE);
    if (state_reg == IDLE && grant_found && !rst)
      req_ready[grant_idx] = 1'b1;
    if (state_reg == RESP) begin
      rsp_valid = 1'b1;
      rsp_sum   = result;
      rsp_cout  = carry_reg;
      rsp_id    = id_reg;
    end
  end

endmodule

// File: tb/tb_k_add_scheduler.sv
// Directed bench for k_add_scheduler: arbitration order, sums, latency, hold and reset abort.

module tb_k_add_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_sum;
  logic        rsp_cout;
  logic [1:0]  rsp_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  k_add_scheduler #(.NUM_REQ(4), .WIDTH(16), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic set_ops(input int p, input logic [15:0] a, input logic [15:0] b);
    req_a[p*16 +: 16] = a;
    req_b[p*16 +: 16] = b;
  endtask

  // Called 1 ns after the accept edge; waits (bounded) for the response.
  task automatic wait_resp(input string tag, input int exp_lat, input logic [15:0] es,
                           input logic ec, input logic [1:0] eid);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_sum"}, rsp_sum, es);
    check({tag, "_cout"}, rsp_cout, ec);
    check({tag, "_id"}, rsp_id, eid);
  endtask

  logic [15:0] all_a [4] = '{16'h0001, 16'h8000, 16'hAAAA, 16'h7FFF};
  logic [15:0] all_b [4] = '{16'h0002, 16'h8000, 16'h5555, 16'h0001};
  logic [15:0] all_s [4] = '{16'h0003, 16'h0000, 16'hFFFF, 16'h8000};
  logic        all_c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int prev_acc, acc, hi_cnt;
    logic [3:0] one;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    prev_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_id", rsp_id, 0);
    rst = 1'b0;

    // All four requesting continuously: grants 0,1,2,3,0 spaced 10 cycles
    for (int p = 0; p < 4; p++) set_ops(p, all_a[p], all_b[p]);
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      one = 4'b0001 << (k % 4);
      check("rr_grant", req_ready, one);
      @(posedge clk); #1;
      acc = cyc;
      if (k > 0) check("rr_spacing", acc - prev_acc, 10);
      prev_acc = acc;
      wait_resp("rr", 8, all_s[k % 4], all_c[k % 4], 2'(k % 4));
      @(posedge clk); #1;
    end
    req_valid = '0;

    // Single request on port 0, operands scrambled after accept
    set_ops(0, 16'h1234, 16'h0FED);
    req_valid = 4'b0001; rsp_ready = 1'b0;
    #1 check("t1_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0; req_a = '1; req_b = '1;
    check("t1_busy", busy, 1);
    wait_resp("t1", 8, 16'h2221, 1'b0, 2'd0);
    check("t1_no_ready", req_ready, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("t1_idle_valid", rsp_valid, 0);
    check("t1_idle_busy", busy, 0);

    // Overflow on port 2 with rsp_ready held high
    set_ops(2, 16'hFFFF, 16'h0001);
    req_valid = 4'b0100;
    #1 check("ovf_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp("ovf", 8, 16'h0000, 1'b1, 2'd2);
    @(posedge clk); #1;
    check("ovf_idle_busy", busy, 0);

    // rr_ptr=3, only port 1 valid: wrap grant; then hold response 5 cycles
    set_ops(1, 16'h00FF, 16'h0F01);
    req_valid = 4'b0010; rsp_ready = 1'b0;
    #1 check("hold_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp("hold", 8, 16'h1000, 1'b0, 2'd1);
    req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_sum", rsp_sum, 16'h1000);
      check("hold_id", rsp_id, 1);
      check("hold_no_ready", req_ready, 0);
    end
    req_valid = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_idle_busy", busy, 0);
    check("hold_idle_valid", rsp_valid, 0);

    // rr_ptr=2, only port 1 valid: wrap search grants 1, pointer stays 2
    set_ops(1, 16'h0003, 16'h0004);
    req_valid = 4'b0010;
    #1 check("wrap_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp("wrap", 8, 16'h0007, 1'b0, 2'd1);
    @(posedge clk); #1;
    req_valid = 4'b1110;
    #1 check("wrap_ptr2", req_ready, 4'b0100);
    req_valid = '0;
    #1;

    // Reset at digit 3 of an operation from requester 1
    rsp_ready = 1'b1;
    set_ops(1, 16'h1111, 16'h2222);
    req_valid = 4'b0010;
    #1 check("abort_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", rsp_sum, 0);
    check("abort_cout", rsp_cout, 0);
    check("abort_id", rsp_id, 0);
    hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) hi_cnt++;
    end
    check("abort_no_rsp", hi_cnt, 0);
    req_valid = 4'b1001;
    #1 check("abort_ptr0", req_ready, 4'b0001);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
